fft_se2pa_sequencer: RTL and testbench

Frame sequencer that sits between the serial sample source and the 4-way serial-to-parallel converter (SE2PA) at the head of the 32-point FFT pipeline. The converter only produces one RDY per START, so this block frames the stream, re-issues START on the first sample of every 4-sample group, and tracks the RDY expected for each group. It qualifies each converter output word with a group index and an end-of-frame marker. It also detects framing faults: input gaps, early SOP and missing RDY.

---
 rtl/fft_se2pa_sequencer_if.sv | 40 ++++
 rtl/fft_se2pa_sequencer.sv | 174 +++++++++++++++++
 tb/tb_fft_se2pa_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_se2pa_sequencer_if.sv
// Bus between the serial sample source / SE2PA converter and the frame sequencer.
// Signal suffixes are from the sequencer's point of view.
//   en_i, in_valid_i, in_sop_i, dr_i, di_i : serial sample stream and frame enable
//   sp_start_o, sp_dr_o, sp_di_o          : START and sample towards the SE2PA
//   sp_rdy_i                              : RDY back from the SE2PA
//   grp_valid_o, grp_idx_o, frame_done_o  : qualification of the SE2PA output group
//   busy_o, err_o, clr_err_i              : status, sticky errors and their clear
// The slave modport is the sequencer; the master modport is its environment.
interface fft_se2pa_sequencer_if #(
    parameter int unsigned Nb = 16,
    parameter int unsigned Gw = 3
);
    logic          en_i;
    logic          in_valid_i;
    logic          in_sop_i;
    logic [Nb-1:0] dr_i;
    logic [Nb-1:0] di_i;
    logic          sp_start_o;
    logic [Nb-1:0] sp_dr_o;
    logic [Nb-1:0] sp_di_o;
    logic          sp_rdy_i;
    logic          grp_valid_o;
    logic [Gw-1:0] grp_idx_o;
    logic          frame_done_o;
    logic          busy_o;
    logic [2:0]    err_o;
    logic          clr_err_i;

    modport master (
        output en_i, in_valid_i, in_sop_i, dr_i, di_i, sp_rdy_i, clr_err_i,
        input  sp_start_o, sp_dr_o, sp_di_o, grp_valid_o, grp_idx_o, frame_done_o,
               busy_o, err_o
    );

    modport slave (
        input  en_i, in_valid_i, in_sop_i, dr_i, di_i, sp_rdy_i, clr_err_i,
        output sp_start_o, sp_dr_o, sp_di_o, grp_valid_o, grp_idx_o, frame_done_o,
               busy_o, err_o
    );
endinterface

// File: rtl/fft_se2pa_sequencer.sv
// Frame sequencer in front of the 4-way serial-to-parallel converter (SE2PA).
// Frames the serial stream into N-sample frames, re-issues START on sample 0 of every
// 4-sample group and tracks the RDY expected 5 cycles after each group start.
// Ports:
//   clk_i : rising-edge clock
//   rst_i : asynchronous active-high reset
//   bus   : sequencer side (slave) of fft_se2pa_sequencer_if
// err_o bits are sticky {rdy_missing, sop_mid_frame, gap}.
module fft_se2pa_sequencer #(
    parameter int unsigned Nb = 16,
    parameter int unsigned N  = 32
) (
    input logic                  clk_i,
    input logic                  rst_i,
    fft_se2pa_sequencer_if.slave bus
);
    localparam int unsigned PosW  = $clog2(N);
    localparam int unsigned Gw    = PosW - 2;
    localparam int unsigned Depth = 5;

    localparam logic [PosW-1:0] PosOne  = PosW'(1);
    localparam logic [PosW-1:0] PosLast = PosW'(N - 1);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [PosW-1:0] pos_q, pos_d;

    logic            accept;
    logic [PosW-1:0] acc_pos;
    logic            cancel;
    logic            gap_err;
    logic            sop_err;
    logic            rdy_err;

    logic            sp_start_q, sp_start_d;
    logic [Nb-1:0]   sp_dr_q, sp_dr_d;
    logic [Nb-1:0]   sp_di_q, sp_di_d;

    // Pending-group delay line; index 0 is stage 1, index Depth-1 is the RDY stage.
    logic [Depth-1:0] vld_q, vld_d;
    logic [Depth-1:0] last_q;
    logic [Gw-1:0]    idx_q [Depth];
    logic [Depth-1:0] kill;
    logic             load;
    logic [Gw-1:0]    load_idx;
    logic             load_last;

    logic [2:0]       err_q, err_d;

    // Framing FSM: decides whether the current sample is accepted and at which position.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        accept  = 1'b0;
        acc_pos = '0;
        cancel  = 1'b0;
        gap_err = 1'b0;
        sop_err = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.in_valid_i && bus.in_sop_i && bus.en_i) begin
                    accept  = 1'b1;
                    state_d = StRun;
                    pos_d   = PosOne;
                end
            end
            default: begin
                if (!bus.in_valid_i) begin
                    gap_err = 1'b1;
                    cancel  = (pos_q[1:0] != 2'b00);
                    state_d = StIdle;
                    pos_d   = '0;
                end else if (bus.in_sop_i) begin
                    sop_err = 1'b1;
                    cancel  = (pos_q[1:0] != 2'b00);
                    if (bus.en_i) begin
                        accept  = 1'b1;
                        state_d = StRun;
                        pos_d   = PosOne;
                    end else begin
                        state_d = StIdle;
                        pos_d   = '0;
                    end
                end else begin
                    accept  = 1'b1;
                    acc_pos = pos_q;
                    // Wraps to 0 on the last sample since N is a power of 2.
                    pos_d   = pos_q + PosOne;
                    if (pos_q == PosLast) begin
                        state_d = StIdle;
                    end
                end
            end
        endcase
    end

    assign load      = accept && (acc_pos[1:0] == 2'b00);
    assign load_idx  = acc_pos[PosW-1:2];
    assign load_last = &acc_pos[PosW-1:2];

    // The incomplete group started pos mod 4 samples ago, so its entry sits in that stage.
    always_comb begin
        kill = '0;
        for (int i = 0; i < Depth; i++) begin
            kill[i] = cancel && (int'(pos_q[1:0]) == i + 1);
        end
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = load;
        for (int i = 1; i < Depth; i++) begin
            vld_d[i] = vld_q[i-1] && !kill[i-1];
        end
    end

    always_comb begin
        sp_start_d = load;
        sp_dr_d    = sp_dr_q;
        sp_di_d    = sp_di_q;
        if (accept) begin
            sp_dr_d = bus.dr_i;
            sp_di_d = bus.di_i;
        end
    end

    assign rdy_err = vld_q[Depth-1] && !bus.sp_rdy_i;

    // A set condition in the same cycle as the clear wins.
    always_comb begin
        err_d = bus.clr_err_i ? 3'b000 : err_q;
        err_d = err_d | {rdy_err, sop_err, gap_err};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            pos_q      <= '0;
            sp_start_q <= 1'b0;
            sp_dr_q    <= '0;
            sp_di_q    <= '0;
            vld_q      <= '0;
            last_q     <= '0;
            for (int i = 0; i < Depth; i++) begin
                idx_q[i] <= '0;
            end
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            sp_start_q <= sp_start_d;
            sp_dr_q    <= sp_dr_d;
            sp_di_q    <= sp_di_d;
            vld_q      <= vld_d;
            last_q     <= {last_q[Depth-2:0], load_last};
            idx_q[0]   <= load_idx;
            for (int i = 1; i < Depth; i++) begin
                idx_q[i] <= idx_q[i-1];
            end
            err_q      <= err_d;
        end
    end

    assign bus.sp_start_o   = sp_start_q;
    assign bus.sp_dr_o      = sp_dr_q;
    assign bus.sp_di_o      = sp_di_q;
    assign bus.grp_valid_o  = vld_q[Depth-1] && bus.sp_rdy_i;
    assign bus.grp_idx_o    = idx_q[Depth-1];
    assign bus.frame_done_o = vld_q[Depth-1] && bus.sp_rdy_i && last_q[Depth-1];
    assign bus.busy_o       = (state_q == StRun) || (|vld_q);
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_fft_se2pa_sequencer.sv
// Directed testbench for fft_se2pa_sequencer. A small SE2PA model answers every
// SP_START with RDY four cycles later; GRP_VALID pulses are logged and compared with
// hand-derived cycle/index/done lists.
module tb_fft_se2pa_sequencer;
    localparam int unsigned Nb = 16;
    localparam int unsigned N  = 32;
    localparam int unsigned Gw = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fft_se2pa_sequencer_if #(.Nb(Nb), .Gw(Gw)) bus ();

    fft_se2pa_sequencer #(.Nb(Nb), .N(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int          cyc    = 0;
    int          drop_at = -1;
    logic [3:0]  hist   = 4'b0000;
    int          s;

    int g_cyc[$], g_idx[$], g_done[$];
    int e_cyc[$], e_idx[$], e_done[$];
    int s_cyc[$], s_dr[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, sample outputs 1 time unit later.
    task automatic step(input logic v, input logic sop, input logic en, input int d,
                        input logic clr);
        @(negedge clk);
        cyc++;
        bus.sp_rdy_i   = hist[3] && (cyc != drop_at);
        hist           = {hist[2:0], bus.sp_start_o === 1'b1};
        bus.in_valid_i = v;
        bus.in_sop_i   = sop;
        bus.en_i       = en;
        bus.dr_i       = 16'(d);
        bus.di_i       = ~16'(d);
        bus.clr_err_i  = clr;
        #1;
        if (bus.grp_valid_o === 1'b1) begin
            g_cyc.push_back(cyc);
            g_idx.push_back(int'(bus.grp_idx_o));
            g_done.push_back(int'(bus.frame_done_o));
        end
        if (bus.sp_start_o === 1'b1) begin
            s_cyc.push_back(cyc);
            s_dr.push_back(int'(bus.sp_dr_o));
        end
    endtask

    task automatic seg(input int n, input logic sop, input int base);
        for (int k = 0; k < n; k++) begin
            step(1'b1, sop && (k == 0), 1'b1, base + k, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b0, 1'b1, 0, 1'b0);
        end
    endtask

    // Expected pulses for groups g_first..g_last of a stream whose SOP is at cycle s0.
    task automatic exp_grp(input int s0, input int g_first, input int g_last, input int skip);
        for (int g = g_first; g <= g_last; g++) begin
            if (g != skip) begin
                e_cyc.push_back(s0 + 5 + 4 * g);
                e_idx.push_back(g % 8);
                e_done.push_back((g % 8) == 7 ? 1 : 0);
            end
        end
    endtask

    task automatic compare_log(input string tag);
        int n;
        check({tag, " count"}, g_cyc.size(), e_cyc.size());
        n = (g_cyc.size() < e_cyc.size()) ? g_cyc.size() : e_cyc.size();
        for (int i = 0; i < n; i++) begin
            check({tag, " cyc"}, g_cyc[i], e_cyc[i]);
            check({tag, " idx"}, g_idx[i], e_idx[i]);
            check({tag, " done"}, g_done[i], e_done[i]);
        end
        g_cyc.delete(); g_idx.delete(); g_done.delete();
        e_cyc.delete(); e_idx.delete(); e_done.delete();
        s_cyc.delete(); s_dr.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " sp_start"}, bus.sp_start_o, 0);
        check({tag, " sp_dr"}, bus.sp_dr_o, 0);
        check({tag, " sp_di"}, bus.sp_di_o, 0);
        check({tag, " grp_valid"}, bus.grp_valid_o, 0);
        check({tag, " grp_idx"}, bus.grp_idx_o, 0);
        check({tag, " frame_done"}, bus.frame_done_o, 0);
        check({tag, " busy"}, bus.busy_o, 0);
        check({tag, " err"}, bus.err_o, 0);
    endtask

    task automatic clear_err();
        step(1'b0, 1'b0, 1'b1, 0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 0, 1'b0);
        check("err cleared", bus.err_o, 0);
    endtask

    initial begin
        bus.en_i       = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.in_sop_i   = 1'b0;
        bus.dr_i       = '0;
        bus.di_i       = '0;
        bus.sp_rdy_i   = 1'b0;
        bus.clr_err_i  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(5);

        // Contiguous frame, DR = sample index.
        s = cyc + 1;
        seg(16, 1'b1, 0);
        check("t1 busy mid", bus.busy_o, 1);
        for (int k = 16; k < 32; k++) step(1'b1, 1'b0, 1'b0, k, 1'b0);
        idle(12);
        check("t1 start count", s_cyc.size(), 8);
        for (int g = 0; g < 8 && g < s_cyc.size(); g++) begin
            check("t1 start cyc", s_cyc[g], s + 1 + 4 * g);
            check("t1 start dr", s_dr[g], 4 * g);
        end
        check("t1 err", bus.err_o, 0);
        check("t1 busy end", bus.busy_o, 0);
        exp_grp(s, 0, 7, -1);
        compare_log("t1 grp");

        // Two back-to-back frames.
        s = cyc + 1;
        seg(32, 1'b1, 100);
        seg(32, 1'b1, 200);
        idle(12);
        check("t2 err", bus.err_o, 0);
        exp_grp(s, 0, 15, -1);
        compare_log("t2 grp");

        // Input gap at pos 10; following non-SOP samples are dropped.
        s = cyc + 1;
        seg(10, 1'b1, 0);
        step(1'b0, 1'b0, 1'b1, 0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 11, 1'b0);
        check("t3 busy after gap", bus.busy_o, 0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1, 12 + k, 1'b0);
        idle(10);
        check("t3 err", bus.err_o, 3'b001);
        check("t3 start count", s_cyc.size(), 3);
        exp_grp(s, 0, 1, -1);
        compare_log("t3 grp");
        clear_err();

        // Early SOP at pos 17 with EN=1 restarts the frame.
        s = cyc + 1;
        seg(17, 1'b1, 0);
        seg(32, 1'b1, 300);
        idle(12);
        check("t4 err", bus.err_o, 3'b010);
        exp_grp(s, 0, 3, -1);
        exp_grp(s + 17, 0, 7, -1);
        compare_log("t4 grp");
        clear_err();

        // RDY withheld for group 5.
        s = cyc + 1;
        drop_at = s + 25;
        seg(32, 1'b1, 0);
        idle(12);
        drop_at = -1;
        check("t5 err", bus.err_o, 3'b100);
        exp_grp(s, 0, 7, 5);
        compare_log("t5 grp");
        clear_err();

        // Asynchronous reset at pos 20, then a fresh frame.
        s = cyc + 1;
        seg(20, 1'b1, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        bus.in_valid_i = 1'b0;
        #1;
        check_reset_outputs("t6 in reset");
        step(1'b0, 1'b0, 1'b1, 0, 1'b0);
        check_reset_outputs("t6 held reset");
        rst = 1'b0;
        idle(10);
        exp_grp(s, 0, 3, -1);
        compare_log("t6 pre grp");
        s = cyc + 1;
        seg(32, 1'b1, 0);
        idle(12);
        check("t6 err", bus.err_o, 0);
        exp_grp(s, 0, 7, -1);
        compare_log("t6 grp");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
